jump_input_conditioner: RTL and testbench
=========================================

JUMP_INPUT_CONDITIONER -- requirements
Module: jump_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning debounce counter width; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 The block SHALL have port clk, input, 1, the 100 MHz system clock and only clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port button_in, input, 1, raw asynchronous push-button level.
REQ-006 The block SHALL have port screen_ready, input, 1, frame-end level from the display controller.
REQ-007 The block SHALL have port btn_level, output, 1, debounced button level.
REQ-008 The block SHALL have port btn_press, output, 1, one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port jump_req, output, 1, sticky jump request presented to the processor's button-status register.
REQ-010 The block SHALL have port press_count, output, 8, accepted presses since reset, modulo 256.

Function
REQ-011 button_in SHALL pass through a two-flop synchronizer before use; no logic SHALL sample it directly.
REQ-012 The FSM SHALL have states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND.
REQ-013 RELEASED SHALL go to PRESS_PEND when sync=1, with counter cleared.
REQ-014 PRESS_PEND SHALL return to RELEASED on sync=0 and SHALL go to PRESSED after DEBOUNCE_CYCLES consecutive sync=1 cycles.
REQ-015 PRESSED SHALL go to RELEASE_PEND on sync=0; RELEASE_PEND SHALL return to PRESSED on sync=1 and SHALL go to RELEASED after DEBOUNCE_CYCLES consecutive sync=0 cycles.
REQ-016 The counter SHALL clear on every state change and SHALL never wrap.
REQ-017 btn_level SHALL be 1 in PRESSED and RELEASE_PEND, and 0 otherwise.
REQ-018 btn_press SHALL be asserted for exactly the one cycle following the PRESS_PEND to PRESSED transition.
REQ-019 Button-to-btn_press latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-020 press_count SHALL increment on btn_press and SHALL wrap 255 to 0.
REQ-021 The block SHALL register screen_ready and SHALL derive frame_edge as its 0-to-1 transition.
REQ-022 jump_req SHALL be set by btn_press and cleared by frame_edge.
REQ-023 When btn_press and frame_edge occur in the same cycle, jump_req SHALL be 1.
REQ-024 A btn_press while jump_req=1 SHALL leave jump_req at 1, with no queueing.

Reset
REQ-025 When reset=1 at a clk edge, the block SHALL force state RELEASED, counter 0, synchronizer flops 0, screen_ready register 0, btn_level 0, btn_press 0, jump_req 0 and press_count 0.
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard all progress; after release, a held button SHALL re-qualify with full latency.

Configuration
REQ-027 With macro JUMP_AUTOREPEAT_EN defined, every frame_edge while btn_level=1 SHALL set jump_req for that cycle, so a held button requests a jump each frame; press_count and btn_press SHALL be unchanged.
REQ-028 With JUMP_AUTOREPEAT_EN undefined, a held button SHALL produce exactly one jump_req assertion.

Structure
REQ-029 Package dino_pkg SHALL hold the FSM state enum type and the constants DEBOUNCE_CYCLES_DEFAULT and PRESS_COUNT_W.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (1-bit, clk/reset), reusable for other asynchronous inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, then button_in=1 held: btn_press SHALL pulse once at cycle 7, btn_level=1 from cycle 7, and press_count SHALL be 1.
REQ-032 Bounce 1,0,1,0 on successive cycles, then hold at 0: btn_press SHALL never assert, and state SHALL return to RELEASED.
REQ-033 Press accepted, then screen_ready rising 10 cycles later: jump_req SHALL be 1 until frame_edge and 0 on the following cycle.
REQ-034 btn_press and frame_edge aligned in the same cycle: jump_req SHALL remain 1.
REQ-035 With the button held and three screen_ready rises: jump_req SHALL be set once without JUMP_AUTOREPEAT_EN and set on all three frames with it.
REQ-036 256 clean presses: press_count SHALL read 0; then assert reset mid-PRESS_PEND: all outputs SHALL be 0 on the next cycle.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and constants for the jump input path.
// Latency: n/a. Backpressure: n/a.
package dino_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int PRESS_COUNT_W           = 8;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 clk cycles. Backpressure: none, free-running level path.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jump_input_conditioner.sv
// Debounces the jump button, counts presses and holds a sticky per-frame jump request.
// Latency: button to btn_press is 2 + DEBOUNCE_CYCLES + 1 cycles. Backpressure: none;
// a press while jump_req is already set is absorbed. Option: JUMP_AUTOREPEAT_EN.
module jump_input_conditioner
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     button_in,
    input  logic                     screen_ready,
    output logic                     btn_level,
    output logic                     btn_press,
    output logic                     jump_req,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic button_sync;
    logic press_evt;
    logic screen_ready_q;
    logic frame_edge;
    logic jump_set;

    sync_2ff u_sync_button (
        .clk   (clk),
        .reset (reset),
        .d     (button_in),
        .q     (button_sync)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        case (state)
            RELEASED: begin
                if (button_sync) state_nxt = PRESS_PEND;
            end
            PRESS_PEND: begin
                if (!button_sync) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!button_sync) state_nxt = RELEASE_PEND;
            end
            RELEASE_PEND: begin
                if (button_sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
        // The counter only ever measures time spent in the current state.
        if (state_nxt != state) cnt_nxt = '0;
    end

    assign btn_level  = (state == PRESSED) || (state == RELEASE_PEND);
    assign frame_edge = screen_ready & ~screen_ready_q;

`ifdef JUMP_AUTOREPEAT_EN
    assign jump_set = btn_press | (btn_level & frame_edge);
`else
    assign jump_set = btn_press;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RELEASED;
            cnt            <= '0;
            btn_press      <= 1'b0;
            press_count    <= '0;
            jump_req       <= 1'b0;
            screen_ready_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            btn_press      <= press_evt;
            screen_ready_q <= screen_ready;
            if (press_evt) press_count <= press_count + 1'b1;
            // Set wins over the frame clear so a press landing on a frame edge is kept.
            jump_req       <= jump_set | (jump_req & ~frame_edge);
        end
    end

endmodule

// File: tb/tb_jump_input_conditioner.sv
// Bench for jump_input_conditioner with DEBOUNCE_CYCLES=4: run-length reference model
// compared every cycle, plus directed literal checks for the key scenarios.
module tb_jump_input_conditioner;
    import dino_pkg::*;

    localparam int DEB = 4;
`ifdef JUMP_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_in = 1'b0;
    logic       screen_ready = 1'b0;
    logic       btn_level;
    logic       btn_press;
    logic       jump_req;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    // Reference model: sync delay line, debounced level with a run length of disagreeing samples.
    bit       m_s1, m_s2, m_lvl, m_press, m_jump, m_sr;
    int       m_run;
    bit [7:0] m_cnt;

    jump_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .screen_ready (screen_ready),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .jump_req     (jump_req),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit b, input bit sr);
        bit s, fe, jn, pn;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_jump = 0; m_sr = 0;
            m_run = 0; m_cnt = 0;
        end else begin
            s  = m_s2;
            fe = sr & ~m_sr;
            jn = m_press | (AR & m_lvl & fe) | (m_jump & ~fe);
            pn = 0;
            if (s == m_lvl) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    if (m_lvl) begin
                        pn = 1;
                        m_cnt++;
                    end
                end
            end
            m_press = pn;
            m_jump  = jn;
            m_s2    = m_s1;
            m_s1    = b;
            m_sr    = sr;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic tick(input bit r, input bit b, input bit sr);
        reset        = r;
        button_in    = b;
        screen_ready = sr;
        @(posedge clk);
        model_step(r, b, sr);
        #1;
        chk("btn_level",   32'(btn_level),   32'(m_lvl));
        chk("btn_press",   32'(btn_press),   32'(m_press));
        chk("jump_req",    32'(jump_req),    32'(m_jump));
        chk("press_count", 32'(press_count), 32'(m_cnt));
    endtask

    initial begin
        bit seen_press;
        int hits;
        bit bv, sv, rv;
        int left;

        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("reset_level", 32'(btn_level), 32'd0);
        chk("reset_press", 32'(btn_press), 32'd0);
        chk("reset_jump",  32'(jump_req),  32'd0);
        chk("reset_count", 32'(press_count), 32'd0);

        // Held press: pulse exactly at cycle 7.
        for (int k = 1; k <= 10; k++) begin
            tick(0, 1, 0);
            if (k == 6) chk("lat_press_c6", 32'(btn_press), 32'd0);
            if (k == 7) begin
                chk("lat_press_c7", 32'(btn_press), 32'd1);
                chk("lat_level_c7", 32'(btn_level), 32'd1);
                chk("lat_count_c7", 32'(press_count), 32'd1);
            end
            if (k == 8) begin
                chk("lat_press_c8", 32'(btn_press), 32'd0);
                chk("lat_jump_c8",  32'(jump_req),  32'd1);
            end
        end
        for (int k = 0; k < 10; k++) tick(0, 0, 0);
        chk("release_level", 32'(btn_level), 32'd0);

        // Bounce never qualifies.
        seen_press = 0;
        for (int k = 0; k < 14; k++) begin
            tick(0, (k < 4) ? ((k % 2) == 0) : 1'b0, 0);
            if (btn_press) seen_press = 1;
        end
        chk("bounce_no_press", 32'(seen_press), 32'd0);
        chk("bounce_state",    32'(dut.state), 32'(RELEASED));
        chk("bounce_count",    32'(press_count), 32'd1);

        // Clear the leftover request with a frame, then press and frame 10 cycles later.
        tick(0, 0, 1);
        tick(0, 0, 0);
        chk("frame_clear", 32'(jump_req), 32'd0);
        for (int k = 1; k <= 17; k++) tick(0, 1, 0);
        chk("pre_frame_jump", 32'(jump_req), 32'd1);
        tick(0, 1, 1);
        chk("post_frame_jump", 32'(jump_req), 32'd0);
        tick(0, 1, 1);
        tick(0, 1, 0);

        // Press and frame edge in the same cycle.
        for (int k = 0; k < 10; k++) tick(0, 0, 0);
        for (int k = 1; k <= 7; k++) tick(0, 1, 0);
        chk("align_press", 32'(btn_press), 32'd1);
        chk("align_jump_before", 32'(jump_req), 32'd0);
        tick(0, 1, 1);
        chk("align_jump", 32'(jump_req), 32'd1);
        tick(0, 1, 1);
        chk("align_jump_hold", 32'(jump_req), 32'd1);
        tick(0, 1, 0);

        // Button held across three frames.
        hits = 0;
        for (int f = 0; f < 3; f++) begin
            tick(0, 1, 1);
            if (jump_req) hits++;
            for (int k = 0; k < 5; k++) tick(0, 1, 0);
        end
        chk("held_frames", 32'(hits), AR ? 32'd3 : 32'd0);

        // 256 presses wrap the counter.
        tick(1, 0, 0);
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 8; k++) tick(0, 1, 0);
            for (int k = 0; k < 9; k++) tick(0, 0, 0);
        end
        chk("wrap_count", 32'(press_count), 32'd0);
        chk("wrap_jump",  32'(jump_req), 32'd1);

        // Reset mid-debounce discards progress.
        for (int k = 0; k < 4; k++) tick(0, 1, 0);
        chk("mid_state", 32'(dut.state), 32'(PRESS_PEND));
        tick(1, 1, 0);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_press", 32'(btn_press), 32'd0);
        chk("rst_jump",  32'(jump_req), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick(0, 1, 0);
            if (k == 6) chk("requal_c6", 32'(btn_press), 32'd0);
            if (k == 7) chk("requal_c7", 32'(btn_press), 32'd1);
        end

        // Random runs of button levels, frame toggles and occasional resets.
        bv = 0; sv = 0; left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                bv   = 1'($urandom_range(0, 1));
                left = $urandom_range(1, 9);
            end
            left--;
            if ($urandom_range(0, 5) == 0) sv = ~sv;
            rv = ($urandom_range(0, 299) == 0);
            tick(rv, bv, sv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
